// File: rtl/router_ingress_arbiter.sv
// Three-port ingress stage. Each port has its own FIFO, and a round-robin arbiter pops one
// word per cycle into a registered output toward the router. Words addressed to dest 11 are counted, not queued.
module router_ingress_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  in_valid,
    output logic [2:0]  in_ready,
    input  logic [11:0] in_data,
    input  logic [5:0]  in_dest,
    input  logic        stall,
    output logic [3:0]  data_out,
    output logic [1:0]  sel_out,
    output logic        valid_out,
    output logic [1:0]  grant_port,
    output logic [7:0]  drop_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0] push;
    logic [2:0] drop;
    logic [2:0] nonempty;
    logic [2:0] pop;
    logic [2:0] full;
    logic [5:0] head [3];

    logic [1:0] last_grant_reg;
    logic [1:0] winner;
    logic       pop_any;
    logic [5:0] win_word;

    logic       valid_out_reg;
    logic [3:0] data_out_reg;
    logic [1:0] sel_out_reg;
    logic [1:0] grant_port_reg;
    logic [7:0] drop_count_reg;
    logic [7:0] drop_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            logic [5:0]    mem [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic [1:0]    dest;
            logic [3:0]    data;

            assign dest = in_dest[2*gi +: 2];
            assign data = in_data[4*gi +: 4];

            // Readiness depends only on registered occupancy, never on this cycle's pop.
            assign full[gi]     = (count_reg == CW'(FIFO_DEPTH));
            assign nonempty[gi] = (count_reg != '0);
            assign push[gi]     = in_valid[gi] & ~full[gi] & (dest != 2'b11);
            assign drop[gi]     = in_valid[gi] & ~full[gi] & (dest == 2'b11);
            assign pop[gi]      = pop_any & (winner == 2'(gi));
            assign head[gi]     = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= {dest, data};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign in_ready = ~full;

    // Candidate order starts just after the last winner, ending with the last winner itself.
    always_comb begin
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        pop_any = 1'b0;
        winner  = 2'b11;
        case (last_grant_reg)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (!stall) begin
            if (nonempty[c0]) begin
                pop_any = 1'b1;
                winner  = c0;
            end else if (nonempty[c1]) begin
                pop_any = 1'b1;
                winner  = c1;
            end else if (nonempty[c2]) begin
                pop_any = 1'b1;
                winner  = c2;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_word = head[0];
            2'd1:    win_word = head[1];
            default: win_word = head[2];
        endcase
    end

    always_comb begin
        logic [1:0] drop_num;
        logic [8:0] sum;
        drop_num = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
        sum      = {1'b0, drop_count_reg} + {7'b0, drop_num};
        drop_count_next = sum[8] ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 2'd2;
            valid_out_reg  <= 1'b0;
            data_out_reg   <= '0;
            sel_out_reg    <= '0;
            grant_port_reg <= 2'b11;
            drop_count_reg <= '0;
        end else begin
            drop_count_reg <= drop_count_next;
            if (pop_any) begin
                last_grant_reg <= winner;
                valid_out_reg  <= 1'b1;
                data_out_reg   <= win_word[3:0];
                sel_out_reg    <= win_word[5:4];
                grant_port_reg <= winner;
            end else begin
                valid_out_reg  <= 1'b0;
                grant_port_reg <= 2'b11;
            end
        end
    end

    assign valid_out  = valid_out_reg;
    assign data_out   = data_out_reg;
    assign sel_out    = sel_out_reg;
    assign grant_port = grant_port_reg;
    assign drop_count = drop_count_reg;

endmodule
